// File: rtl/i2cm_p2s_shift_ctl_if.sv
// Load/shift/status bundle for i2cm_p2s_shift_ctl.
// master = upstream controller and strobe source; slave = the shifter.
interface i2cm_p2s_shift_ctl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              i_load_vld;
  logic              o_load_rdy;
  logic [DATA_W-1:0] i_data_par;
  logic              i_shift_en;
  logic              i_abort;
  logic              o_data_ser;
  logic              o_busy;
  logic [CNT_W-1:0]  o_bit_cnt;
  logic              o_last_bit;
  logic              o_done;

  modport master (
    output i_load_vld, i_data_par, i_shift_en, i_abort,
    input  o_load_rdy, o_data_ser, o_busy, o_bit_cnt, o_last_bit, o_done
  );

  modport slave (
    input  i_load_vld, i_data_par, i_shift_en, i_abort,
    output o_load_rdy, o_data_ser, o_busy, o_bit_cnt, o_last_bit, o_done
  );
endinterface

// File: rtl/i2cm_p2s_shift_ctl.sv
// Parallel-to-serial SDA shifter with bit counter, valid/ready load and abort.
// Define I2CM_P2S_PREFETCH_EN to add a one-word prefetch buffer for gapless back-to-back words.
module i2cm_p2s_shift_ctl #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  i2cm_p2s_shift_ctl_if.slave    bus
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  localparam int               OUT_IDX  = MSB_FIRST ? DATA_W - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_adv;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_rdy, accept, last_bit, done;

`ifdef I2CM_P2S_PREFETCH_EN
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  assign load_rdy = ~buf_vld_q;
`else
  assign load_rdy = (state_q == ST_IDLE);
`endif

  assign accept   = bus.i_load_vld & load_rdy;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
  // Vacated positions fill with 1 so the line idles released once the word is out.
  assign shift_adv = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b1}
                               : {1'b1, shift_q[DATA_W-1:1]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
`ifdef I2CM_P2S_PREFETCH_EN
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
`endif
    if (bus.i_abort) begin
      state_d = ST_IDLE;
      shift_d = '1;
      cnt_d   = '0;
`ifdef I2CM_P2S_PREFETCH_EN
      buf_vld_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_SHIFT;
            shift_d = bus.i_data_par;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          if (bus.i_shift_en && last_bit) begin
            done    = 1'b1;
            state_d = ST_IDLE;
            shift_d = '1;
            cnt_d   = '0;
`ifdef I2CM_P2S_PREFETCH_EN
            if (buf_vld_q) begin
              state_d   = ST_SHIFT;
              shift_d   = buf_q;
              buf_vld_d = 1'b0;
            end else if (accept) begin
              state_d = ST_SHIFT;
              shift_d = bus.i_data_par;
            end
`endif
          end else begin
            if (bus.i_shift_en) begin
              shift_d = shift_adv;
              cnt_d   = cnt_q + CNT_W'(1);
            end
`ifdef I2CM_P2S_PREFETCH_EN
            if (accept) begin
              buf_d     = bus.i_data_par;
              buf_vld_d = 1'b1;
            end
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef I2CM_P2S_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) buf_vld_q <= 1'b0;
    else     buf_vld_q <= buf_vld_d;
  end

  // NOTE: buffer data is not reset; buf_vld_q alone decides whether it is ever used.
  always_ff @(posedge clk) buf_q <= buf_d;
`endif

  assign bus.o_load_rdy = load_rdy;
  assign bus.o_data_ser = shift_q[OUT_IDX];
  assign bus.o_busy     = (state_q == ST_SHIFT);
  assign bus.o_bit_cnt  = cnt_q;
  assign bus.o_last_bit = last_bit;
  assign bus.o_done     = done;

endmodule
